// File: rtl/fsm_stim_pkg.sv
// -----------------------------------------------------------------------------
// fsm_stim_pkg
// Shared types for the stimulus player that drives the sequence-detector FSM:
//   state_t  - player state (IDLE / PLAY / DONE)
//   sym_t    - 2-bit symbol selecting one of SW1..SW4
//   SYM_SW*  - symbol encodings
//   onehot4  - symbol -> one-hot switch command (bit0=SW1 .. bit3=SW4)
// -----------------------------------------------------------------------------
package fsm_stim_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_SW1 = 2'd0;
    localparam sym_t SYM_SW2 = 2'd1;
    localparam sym_t SYM_SW3 = 2'd2;
    localparam sym_t SYM_SW4 = 2'd3;

    function automatic logic [3:0] onehot4(sym_t s);
        logic [3:0] r;
        r = 4'b0000;
        case (s)
            SYM_SW1: r = 4'b0001;
            SYM_SW2: r = 4'b0010;
            SYM_SW3: r = 4'b0100;
            SYM_SW4: r = 4'b1000;
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fsm_stim_gen_if.sv
// -----------------------------------------------------------------------------
// fsm_stim_gen_if
// Host-side load/control signals and player outputs of fsm_stim_gen.
//   wr_en/wr_sym   load one symbol into the next free slot
//   clr            empty the buffer
//   start/stop     begin / abort playback
//   cmd/cmd_valid  one-hot switch command toward the FSM (SW1..SW4)
//   busy/done      playing / one-cycle completion pulse
//   full/count     buffer occupancy
// Modports: slave = the player, master = the host / bench.
// -----------------------------------------------------------------------------
interface fsm_stim_gen_if
    import fsm_stim_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    sym_t          wr_sym;
    logic          clr;
    logic          start;
    logic          stop;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          busy;
    logic          done;
    logic          full;
    logic [CW-1:0] count;

    modport slave (
        input  wr_en, wr_sym, clr, start, stop,
        output cmd, cmd_valid, busy, done, full, count
    );

    modport master (
        output wr_en, wr_sym, clr, start, stop,
        input  cmd, cmd_valid, busy, done, full, count
    );

endinterface

// File: rtl/fsm_stim_gen.sv
// -----------------------------------------------------------------------------
// fsm_stim_gen
// Programmable stimulus player. A host loads up to DEPTH 2-bit symbols, pulses
// start, and the block replays them as one-hot commands on cmd, each symbol
// held for HOLD_CYC clocks. All outputs are registered.
// Ports:
//   KEY0  clock (rising edge)
//   SW0   asynchronous active-high reset
//   bus   fsm_stim_gen_if.slave (load/control in, cmd/status out)
// Optional build macro FSM_STIM_LOOP_EN: playback wraps to slot 0 without a
// gap, pulsing done with the first symbol of every wrap; only stop or reset
// leave PLAY.
// -----------------------------------------------------------------------------
module fsm_stim_gen
    import fsm_stim_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 1
) (
    input logic          KEY0,
    input logic          SW0,
    fsm_stim_gen_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          full_q, full_d;
    logic          wr_fire;
    sym_t          buf_q [DEPTH];
`ifdef FSM_STIM_LOOP_EN
    // Set on the edge that wraps rd_ptr; the next emitted symbol carries done.
    logic          wrap_q, wrap_d;
`endif

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        hold_cnt_d  = hold_cnt_q;
        count_d     = count_q;
        cmd_d       = 4'b0000;
        cmd_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        wr_fire     = 1'b0;
`ifdef FSM_STIM_LOOP_EN
        wrap_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // clr > start > wr_en; a lower-priority request in the same
                // cycle is dropped, even when start itself is ignored.
                if (bus.clr) begin
                    count_d = '0;
                end else if (bus.start) begin
                    if (count_q != '0) begin
                        state_d    = PLAY;
                        rd_ptr_d   = '0;
                        hold_cnt_d = '0;
                    end
                end else if (bus.wr_en && !full_q) begin
                    wr_fire = 1'b1;
                    count_d = count_q + CW'(1);
                end
            end
            PLAY: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else begin
                    cmd_d       = onehot4(buf_q[rd_ptr_q]);
                    cmd_valid_d = 1'b1;
                    busy_d      = 1'b1;
`ifdef FSM_STIM_LOOP_EN
                    done_d      = wrap_q;
`endif
                    if (hold_cnt_q == HW'(HOLD_CYC - 1)) begin
                        hold_cnt_d = '0;
                        if ({1'b0, rd_ptr_q} == count_q - CW'(1)) begin
`ifdef FSM_STIM_LOOP_EN
                            rd_ptr_d = '0;
                            wrap_d   = 1'b1;
`else
                            state_d  = DONE;
`endif
                        end else begin
                            rd_ptr_d = rd_ptr_q + AW'(1);
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge KEY0 or posedge SW0) begin
        if (SW0) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            count_q     <= '0;
            cmd_q       <= 4'b0000;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            full_q      <= 1'b0;
`ifdef FSM_STIM_LOOP_EN
            wrap_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            count_q     <= count_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            full_q      <= full_d;
`ifdef FSM_STIM_LOOP_EN
            wrap_q      <= wrap_d;
`endif
        end
    end

    // Buffer storage is not reset; count=0 hides stale contents.
    always_ff @(posedge KEY0) begin
        if (wr_fire) begin
            buf_q[count_q[AW-1:0]] <= bus.wr_sym;
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.full      = full_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_fsm_stim_gen.sv
// -----------------------------------------------------------------------------
// tb_fsm_stim_gen
// Directed bench for fsm_stim_gen: one instance with HOLD_CYC=1 (a) and one
// with HOLD_CYC=3 (b), both DEPTH=8, sharing clock and reset. Expected values
// are hand-computed constants. FSM_STIM_LOOP_EN selects the looping checks.
// -----------------------------------------------------------------------------
module tb_fsm_stim_gen;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    fsm_stim_gen_if #(.DEPTH(8)) a ();
    fsm_stim_gen_if #(.DEPTH(8)) b ();

    fsm_stim_gen #(.DEPTH(8), .HOLD_CYC(1)) dut_a (.KEY0(clk), .SW0(rst), .bus(a));
    fsm_stim_gen #(.DEPTH(8), .HOLD_CYC(3)) dut_b (.KEY0(clk), .SW0(rst), .bus(b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [1:0] s);
        a.wr_en = 1'b1; a.wr_sym = s;
        step();
        a.wr_en = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] s);
        b.wr_en = 1'b1; b.wr_sym = s;
        step();
        b.wr_en = 1'b0;
    endtask

    task automatic start_a();
        a.start = 1'b1;
        step();
        a.start = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq [4];
        n_chk = 0; n_fail = 0;
        rst = 1'b1;
        a.wr_en = 0; a.wr_sym = 0; a.clr = 0; a.start = 0; a.stop = 0;
        b.wr_en = 0; b.wr_sym = 0; b.clr = 0; b.start = 0; b.stop = 0;
        #12;
        chk("rst_cmd",   a.cmd, 4'b0000);
        chk("rst_valid", a.cmd_valid, 1'b0);
        chk("rst_busy",  a.busy, 1'b0);
        chk("rst_done",  a.done, 1'b0);
        chk("rst_full",  a.full, 1'b0);
        chk("rst_count", a.count, 4'd0);
        #2 rst = 1'b0;
        step();

`ifdef FSM_STIM_LOOP_EN
        // 2-symbol loop: SW2, SW3 repeating, done with every wrapped SW2.
        wr_a(2'd1); wr_a(2'd2);
        start_a();
        chk("loop_lat", a.cmd, 4'b0000);
        step(); chk("loop_c0", a.cmd, 4'b0010); chk("loop_d0", a.done, 1'b0);
        step(); chk("loop_c1", a.cmd, 4'b0100); chk("loop_d1", a.done, 1'b0);
        step(); chk("loop_c2", a.cmd, 4'b0010); chk("loop_d2", a.done, 1'b1);
        chk("loop_v2", a.cmd_valid, 1'b1);
        step(); chk("loop_c3", a.cmd, 4'b0100); chk("loop_d3", a.done, 1'b0);
        step(); chk("loop_c4", a.cmd, 4'b0010); chk("loop_d4", a.done, 1'b1);
        a.stop = 1'b1;
        step(); a.stop = 1'b0;
        chk("loop_stop_cmd",  a.cmd, 4'b0000);
        chk("loop_stop_busy", a.busy, 1'b0);
        chk("loop_stop_done", a.done, 1'b0);
        chk("loop_count",     a.count, 4'd2);
`else
        // Load and play 2,1,1,1.
        wr_a(2'd2); wr_a(2'd1); wr_a(2'd1); wr_a(2'd1);
        chk("load_count", a.count, 4'd4);
        chk("load_full",  a.full, 1'b0);
        exp_seq[0] = 4'b0100; exp_seq[1] = 4'b0010;
        exp_seq[2] = 4'b0010; exp_seq[3] = 4'b0010;
        start_a();
        chk("play_lat", a.cmd_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("play_cmd%0d", i), a.cmd, exp_seq[i]);
            chk($sformatf("play_busy%0d", i), a.busy, 1'b1);
            chk($sformatf("play_done%0d", i), a.done, 1'b0);
        end
        step();
        chk("play_done",   a.done, 1'b1);
        chk("play_end_cv", a.cmd_valid, 1'b0);
        chk("play_end_bz", a.busy, 1'b0);
        step();
        chk("play_done_pulse", a.done, 1'b0);
        chk("play_count", a.count, 4'd4);

        // Abort during the 2nd symbol, then replay from symbol 0.
        start_a();
        step(); chk("abort_s0", a.cmd, 4'b0100);
        step(); chk("abort_s1", a.cmd, 4'b0010);
        a.stop = 1'b1;
        step(); a.stop = 1'b0;
        chk("abort_cmd",  a.cmd, 4'b0000);
        chk("abort_cv",   a.cmd_valid, 1'b0);
        chk("abort_busy", a.busy, 1'b0);
        chk("abort_done", a.done, 1'b0);
        step();
        chk("abort_done2", a.done, 1'b0);
        chk("abort_count", a.count, 4'd4);
        start_a();
        step(); chk("replay_s0", a.cmd, 4'b0100);
        step(); step(); step(); step();
        chk("replay_done", a.done, 1'b1);
        step();

        // clr together with start: stays IDLE, count cleared.
        a.clr = 1'b1; a.start = 1'b1;
        step(); a.clr = 1'b0; a.start = 1'b0;
        chk("clr_count", a.count, 4'd0);
        step();
        chk("clr_busy", a.busy, 1'b0);
        chk("clr_cv",   a.cmd_valid, 1'b0);

        // start on an empty buffer: ignored, no done.
        start_a();
        step();
        chk("empty_busy", a.busy, 1'b0);
        chk("empty_done", a.done, 1'b0);
        step();
        chk("empty_done2", a.done, 1'b0);

        // start with wr_en on the same edge: write dropped.
        wr_a(2'd3);
        a.start = 1'b1; a.wr_en = 1'b1; a.wr_sym = 2'd0;
        step(); a.start = 1'b0; a.wr_en = 1'b0;
        chk("sw_count", a.count, 4'd1);
        step();
        chk("sw_cmd",  a.cmd, 4'b1000);
        chk("sw_busy", a.busy, 1'b1);
        step();
        chk("sw_done",  a.done, 1'b1);
        chk("sw_count2", a.count, 4'd1);
        step();

        // Overflow: nine writes into eight slots.
        a.clr = 1'b1; step(); a.clr = 1'b0;
        for (int i = 0; i < 8; i++) wr_a(2'(i % 4));
        chk("ovf_full8",  a.full, 1'b1);
        chk("ovf_count8", a.count, 4'd8);
        wr_a(2'd2);
        chk("ovf_full9",  a.full, 1'b1);
        chk("ovf_count9", a.count, 4'd8);
        start_a();
        for (int i = 0; i < 8; i++) begin
            logic [3:0] e;
            step();
            e = 4'b0001 << (i % 4);
            chk($sformatf("ovf_cmd%0d", i), a.cmd, e);
        end
        step();
        chk("ovf_done", a.done, 1'b1);
        chk("ovf_cv",   a.cmd_valid, 1'b0);
        step();

        // HOLD_CYC=3 with sequence 3,2.
        wr_b(2'd3); wr_b(2'd2);
        b.start = 1'b1; step(); b.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("hold_cmd%0d", i), b.cmd, (i < 3) ? 4'b1000 : 4'b0100);
            chk($sformatf("hold_cv%0d", i), b.cmd_valid, 1'b1);
        end
        step();
        chk("hold_done", b.done, 1'b1);
        chk("hold_cmd_end", b.cmd, 4'b0000);
        step();
`endif

        // Reset between edges in the middle of playback.
        start_a();
        step(); step();
        chk("mid_busy", a.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cmd",   a.cmd, 4'b0000);
        chk("mid_rst_busy",  a.busy, 1'b0);
        chk("mid_rst_count", a.count, 4'd0);
        chk("mid_rst_full",  a.full, 1'b0);
        #2 rst = 1'b0;
        step(); step();
        chk("post_rst_cv", a.cmd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
